// File: rtl/rs232c_rx.sv
// 8N1 UART receiver: 16x oversampled, mid-bit sampling, LSB first, with a one-entry holding
// register read through a valid/rd handshake plus sticky framing and overrun flags.
module rs232c_rx #(
    parameter int sys_clk = 14000000,
    parameter int rate    = 9600,
    parameter int OVS     = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    input  logic       rd,
    output logic [7:0] dout,
    output logic       valid,
    output logic       ferr,
    output logic       overrun
);

    localparam int DIV = sys_clk / (rate * OVS) - 1;
    localparam int CW  = (DIV > 0) ? $clog2(DIV + 1) : 1;
    localparam logic [CW-1:0] DIV_W = CW'(DIV);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BRK   = 3'd4
    } state_t;

    logic          rx_meta_reg;
    logic          rxs_reg;
    logic [CW-1:0] div_cnt_reg;
    logic          tick;

    state_t        state_reg, state_next;
    logic [3:0]    scnt_reg, scnt_next;
    logic [2:0]    bcnt_reg, bcnt_next;
    logic [7:0]    sh_reg, sh_next;
    logic [7:0]    dout_reg, dout_next;
    logic          valid_reg, valid_next;
    logic          ferr_reg, ferr_next;
    logic          overrun_reg, overrun_next;

    // Synchronizer flops reset to the idle-high line level so reset release never fakes a start bit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta_reg <= 1'b1;
            rxs_reg     <= 1'b1;
        end else begin
            rx_meta_reg <= rxd;
            rxs_reg     <= rx_meta_reg;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_cnt_reg <= '0;
        end else if (div_cnt_reg == DIV_W) begin
            div_cnt_reg <= '0;
        end else begin
            div_cnt_reg <= div_cnt_reg + 1'b1;
        end
    end

    assign tick = (div_cnt_reg == DIV_W);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg   <= IDLE;
            scnt_reg    <= '0;
            bcnt_reg    <= '0;
            sh_reg      <= '0;
            dout_reg    <= '0;
            valid_reg   <= 1'b0;
            ferr_reg    <= 1'b0;
            overrun_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            scnt_reg    <= scnt_next;
            bcnt_reg    <= bcnt_next;
            sh_reg      <= sh_next;
            dout_reg    <= dout_next;
            valid_reg   <= valid_next;
            ferr_reg    <= ferr_next;
            overrun_reg <= overrun_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        scnt_next    = scnt_reg;
        bcnt_next    = bcnt_reg;
        sh_next      = sh_reg;
        dout_next    = dout_reg;
        valid_next   = valid_reg;
        ferr_next    = ferr_reg;
        overrun_next = overrun_reg;

        // A read retires the held byte; a frame completing in the same clk may refill it below.
        if (rd && valid_reg) begin
            valid_next   = 1'b0;
            overrun_next = 1'b0;
        end

        case (state_reg)
            IDLE: begin
                if (tick && !rxs_reg) begin
                    state_next = START;
                    scnt_next  = '0;
                end
            end
            START: begin
                if (tick) begin
                    if (scnt_reg == 4'd7) begin
                        if (!rxs_reg) begin
                            state_next = DATA;
                            scnt_next  = '0;
                            bcnt_next  = '0;
                        end else begin
                            state_next = IDLE;
                        end
                    end else begin
                        scnt_next = scnt_reg + 4'd1;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    scnt_next = scnt_reg + 4'd1;
                    if (scnt_reg == 4'd15) begin
                        sh_next   = {rxs_reg, sh_reg[7:1]};
                        bcnt_next = bcnt_reg + 3'd1;
                        if (bcnt_reg == 3'd7) begin
                            state_next = STOP;
                        end
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    scnt_next = scnt_reg + 4'd1;
                    if (scnt_reg == 4'd15) begin
                        if (rxs_reg) begin
                            if (!valid_reg || rd) begin
                                dout_next  = sh_reg;
                                valid_next = 1'b1;
                                ferr_next  = 1'b0;
                            end else begin
                                overrun_next = 1'b1;
                            end
                            state_next = IDLE;
                        end else begin
                            ferr_next  = 1'b1;
                            state_next = BRK;
                        end
                    end
                end
            end
            BRK: begin
                if (tick && rxs_reg) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign dout    = dout_reg;
    assign valid   = valid_reg;
    assign ferr    = ferr_reg;
    assign overrun = overrun_reg;

endmodule
